// File: rtl/pong_game_controller.sv
// Pong game sequencer: goal detection, scoring and serve/play/point/game-over phasing.
// Optional build macro PONG_WIN_BY_TWO_EN selects win-by-two with a hard cap at 15.
module pong_game_controller #(
  parameter int unsigned DISP_COLS          = 800,
  parameter int unsigned B_WIDTH            = 6,
  parameter int unsigned WIN_SCORE          = 7,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned POINT_DELAY_FRAMES = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic [11:0] ball_center_col,
  output logic        ball_reset,
  output logic        ball_enable,
  output logic        serve_dir,
  output logic [3:0]  score_p0,
  output logic [3:0]  score_p1,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  localparam logic [11:0] L_LIM      = 12'(B_WIDTH / 2);
  localparam logic [11:0] R_LIM      = 12'(DISP_COLS - 1 - B_WIDTH / 2);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_DELAY_FRAMES - 1);
  localparam logic [7:0]  POINT_LAST = 8'(POINT_DELAY_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  score0_q, score0_d;
  logic [3:0]  score1_q, score1_d;
  logic        serve_dir_q, serve_dir_d;
  logic        winner_q, winner_d;
  logic        game_over_q, game_over_d;
  logic        ball_reset_q, ball_reset_d;
  logic        ball_enable_q, ball_enable_d;
  logic        start_q;

  logic start_rise, l_goal, r_goal, win, win_p1;

  assign start_rise = start_btn & ~start_q;
  assign l_goal     = ball_center_col <= L_LIM;
  assign r_goal     = ball_center_col >= R_LIM;

`ifdef PONG_WIN_BY_TWO_EN
  logic [3:0] lead, margin;
  always_comb begin
    lead   = (score1_q > score0_q) ? score1_q : score0_q;
    margin = (score1_q > score0_q) ? (score1_q - score0_q) : (score0_q - score1_q);
    win    = ((lead >= WIN) && (margin >= 4'd2)) || (score0_q == 4'd15) || (score1_q == 4'd15);
    // On a tie the last scorer wins; serve goes toward whoever conceded.
    win_p1 = (score1_q > score0_q) || ((score1_q == score0_q) && !serve_dir_q);
  end
`else
  always_comb begin
    win    = (score0_q == WIN) || (score1_q == WIN);
    win_p1 = score1_q > score0_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      score0_q      <= '0;
      score1_q      <= '0;
      serve_dir_q   <= 1'b0;
      winner_q      <= 1'b0;
      game_over_q   <= 1'b0;
      ball_reset_q  <= 1'b1;
      ball_enable_q <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score0_q      <= score0_d;
      score1_q      <= score1_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      game_over_q   <= game_over_d;
      ball_reset_q  <= ball_reset_d;
      ball_enable_q <= ball_enable_d;
      start_q       <= start_btn;
    end
  end

  always_comb begin
    state_d     = state_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      S_IDLE: if (start_rise) state_d = S_SERVE;
      S_SERVE: if (frame_tick && (cnt_q == SERVE_LAST)) state_d = S_PLAY;
      S_PLAY: begin
        if (l_goal) begin
          if (score1_q != 4'd15) score1_d = score1_q + 4'd1;
          serve_dir_d = 1'b0;
          state_d     = S_POINT;
        end else if (r_goal) begin
          if (score0_q != 4'd15) score0_d = score0_q + 4'd1;
          serve_dir_d = 1'b1;
          state_d     = S_POINT;
        end
      end
      S_POINT: begin
        if (frame_tick && (cnt_q == POINT_LAST)) begin
          if (win) begin
            state_d  = S_GAME_OVER;
            winner_d = win_p1;
          end else begin
            state_d = S_SERVE;
          end
        end
      end
      S_GAME_OVER: begin
        if (start_rise) begin
          score0_d    = '0;
          score1_d    = '0;
          serve_dir_d = 1'b0;
          state_d     = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Any state change restarts the frame counter, so a tick coincident with a goal is dropped.
    cnt_d = (state_d != state_q) ? '0 : (cnt_q + {7'd0, frame_tick});
  end

  // Outputs are decoded from the next state so they register in step with state_q.
  always_comb begin
    ball_reset_d  = 1'b1;
    ball_enable_d = 1'b0;
    game_over_d   = 1'b0;
    case (state_d)
      S_PLAY: begin
        ball_reset_d  = 1'b0;
        ball_enable_d = 1'b1;
      end
      S_POINT:     ball_reset_d = 1'b0;
      S_GAME_OVER: game_over_d  = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign score_p0    = score0_q;
  assign score_p1    = score1_q;
  assign serve_dir   = serve_dir_q;
  assign winner      = winner_q;
  assign game_over   = game_over_q;
  assign ball_reset  = ball_reset_q;
  assign ball_enable = ball_enable_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed testbench for pong_game_controller with hand-computed expectations.
// The win-by-two scenario is included only when PONG_WIN_BY_TWO_EN is defined.
module tb_pong_game_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic [11:0] ball_center_col = 12'd400;
  logic        ball_reset, ball_enable, serve_dir, game_over, winner;
  logic [3:0]  score_p0, score_p1;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  pong_game_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .ball_center_col(ball_center_col), .ball_reset(ball_reset), .ball_enable(ball_enable),
    .serve_dir(serve_dir), .score_p0(score_p0), .score_p1(score_p1),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_btn = 1'b0; frame_tick = 1'b0; ball_center_col = 12'd400;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic press_start();
    start_btn = 1'b1; cyc();
    start_btn = 1'b0; cyc();
  endtask

  // From SERVE: launch, score on the chosen side, then sit out the point pause.
  task automatic play_point(input bit right);
    ticks(60);
    ball_center_col = right ? 12'd796 : 12'd3;
    cyc();
    ball_center_col = 12'd400;
    ticks(90);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (score_p0 !== 4'd0 || score_p1 !== 4'd0) begin failures++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_p0, score_p1); end
    checks++; if ({ball_reset, ball_enable, serve_dir, game_over, winner} !== 5'b10000) begin failures++; $display("FAIL reset_flags got=%b exp=10000", {ball_reset, ball_enable, serve_dir, game_over, winner}); end
    rst_n = 1'b1;
    cyc();
    ticks(5);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
  endtask

  task automatic test_serve();
    press_start();
    checks++; if (state !== 3'd1 || ball_reset !== 1'b1 || ball_enable !== 1'b0) begin failures++; $display("FAIL serve_entry got=%0d br=%b be=%b exp=1 br=1 be=0", state, ball_reset, ball_enable); end
    ticks(59);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL serve_59 got=%0d exp=1", state); end
    ticks(1);
    checks++; if (state !== 3'd2 || ball_enable !== 1'b1 || ball_reset !== 1'b0) begin failures++; $display("FAIL play_entry got=%0d br=%b be=%b exp=2 br=0 be=1", state, ball_reset, ball_enable); end
    ball_center_col = 12'd4; repeat (5) cyc();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL no_lgoal_4 got=%0d exp=2", state); end
    ball_center_col = 12'd795; repeat (5) cyc();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL no_rgoal_795 got=%0d exp=2", state); end
    ball_center_col = 12'd400;
    press_start();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL start_in_play got=%0d exp=2", state); end
  endtask

  task automatic test_left_goal();
    ball_center_col = 12'd3; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    repeat (499) cyc();
    checks++; if (score_p1 !== 4'd1 || score_p0 !== 4'd0) begin failures++; $display("FAIL lgoal_score got=%0d/%0d exp=0/1", score_p0, score_p1); end
    checks++; if (state !== 3'd3 || serve_dir !== 1'b0 || ball_enable !== 1'b0 || ball_reset !== 1'b0) begin failures++; $display("FAIL lgoal_point got=%0d sd=%b be=%b br=%b exp=3 sd=0 be=0 br=0", state, serve_dir, ball_enable, ball_reset); end
    ball_center_col = 12'd400;
    ticks(89);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL point_89 got=%0d exp=3", state); end
    ticks(1);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL point_exit got=%0d exp=1", state); end
  endtask

  task automatic test_right_goal();
    ticks(60);
    ball_center_col = 12'd796;
    cyc();
    ball_center_col = 12'd400;
    checks++; if (score_p0 !== 4'd1 || score_p1 !== 4'd1 || serve_dir !== 1'b1 || state !== 3'd3) begin failures++; $display("FAIL rgoal got=%0d/%0d sd=%b st=%0d exp=1/1 sd=1 st=3", score_p0, score_p1, serve_dir, state); end
    ticks(90);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rgoal_serve got=%0d exp=1", state); end
  endtask

  task automatic test_game_over();
    do_reset();
    press_start();
    repeat (6) play_point(1'b1);
    checks++; if (state !== 3'd1 || score_p0 !== 4'd6 || game_over !== 1'b0) begin failures++; $display("FAIL six_zero got=%0d st=%0d go=%b exp=6 st=1 go=0", score_p0, state, game_over); end
    play_point(1'b1);
    checks++; if (state !== 3'd4 || game_over !== 1'b1 || winner !== 1'b0 || ball_reset !== 1'b1) begin failures++; $display("FAIL p0_wins st=%0d go=%b w=%b br=%b exp=4 1 0 1", state, game_over, winner, ball_reset); end
    checks++; if (score_p0 !== 4'd7 || score_p1 !== 4'd0) begin failures++; $display("FAIL p0_final got=%0d/%0d exp=7/0", score_p0, score_p1); end
    start_btn = 1'b1;
    repeat (100) cyc();
    checks++; if (state !== 3'd1 || score_p0 !== 4'd0 || score_p1 !== 4'd0 || game_over !== 1'b0 || serve_dir !== 1'b0) begin failures++; $display("FAIL restart st=%0d sc=%0d/%0d go=%b sd=%b exp=1 0/0 0 0", state, score_p0, score_p1, game_over, serve_dir); end
    start_btn = 1'b0;
    ticks(59);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL restart_serve59 got=%0d exp=1", state); end
    ticks(1);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL restart_play got=%0d exp=2", state); end
  endtask

  task automatic test_p1_wins();
    do_reset();
    press_start();
    repeat (7) play_point(1'b0);
    checks++; if (state !== 3'd4 || winner !== 1'b1 || score_p1 !== 4'd7 || score_p0 !== 4'd0) begin failures++; $display("FAIL p1_wins st=%0d w=%b sc=%0d/%0d exp=4 1 0/7", state, winner, score_p0, score_p1); end
  endtask

  task automatic test_reset_mid_point();
    do_reset();
    press_start();
    play_point(1'b0); play_point(1'b0); play_point(1'b1); play_point(1'b1);
    ticks(60);
    ball_center_col = 12'd796;
    cyc();
    ball_center_col = 12'd400;
    ticks(40);
    checks++; if (state !== 3'd3 || score_p0 !== 4'd3 || score_p1 !== 4'd2 || serve_dir !== 1'b1) begin failures++; $display("FAIL pre_reset st=%0d sc=%0d/%0d sd=%b exp=3 3/2 1", state, score_p0, score_p1, serve_dir); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || score_p0 !== 4'd0 || score_p1 !== 4'd0) begin failures++; $display("FAIL async_reset st=%0d sc=%0d/%0d exp=0 0/0", state, score_p0, score_p1); end
    checks++; if ({ball_reset, ball_enable, serve_dir, game_over, winner} !== 5'b10000) begin failures++; $display("FAIL async_flags got=%b exp=10000", {ball_reset, ball_enable, serve_dir, game_over, winner}); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    ticks(10);
    checks++; if (state !== 3'd0 || ball_reset !== 1'b1) begin failures++; $display("FAIL post_reset_idle st=%0d br=%b exp=0 1", state, ball_reset); end
    press_start();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL post_reset_start got=%0d exp=1", state); end
  endtask

`ifdef PONG_WIN_BY_TWO_EN
  task automatic test_win_by_two();
    do_reset();
    press_start();
    for (int i = 0; i < 6; i++) begin
      play_point(1'b1);
      play_point(1'b0);
    end
    play_point(1'b1);
    checks++; if (state !== 3'd1 || score_p0 !== 4'd7 || score_p1 !== 4'd6) begin failures++; $display("FAIL wb2_7_6 st=%0d sc=%0d/%0d exp=1 7/6", state, score_p0, score_p1); end
    play_point(1'b1);
    checks++; if (state !== 3'd4 || winner !== 1'b0 || score_p0 !== 4'd8) begin failures++; $display("FAIL wb2_8_6 st=%0d w=%b p0=%0d exp=4 0 8", state, winner, score_p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_serve();
    test_left_goal();
    test_right_goal();
    test_game_over();
    test_p1_wins();
    test_reset_mid_point();
`ifdef PONG_WIN_BY_TWO_EN
    test_win_by_two();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
